// File: rtl/apb4_arb_pkg.sv
// apb4_arb_pkg: shared types and widths for the
// round-robin APB4 master arbiter.
package apb4_arb_pkg;

  localparam int APB_DW = 32;
  localparam int APB_SW = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

endpackage

// File: rtl/apb4_rr_pick.sv
// apb4_rr_pick: combinational round-robin picker.
// Scans upward from ptr_i+1 (mod NREQ) for the first set request.
module apb4_rr_pick
  import apb4_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic            any_o,
  output logic [IW-1:0]   idx_o
);

  function automatic logic [IW-1:0] wrap_idx(
    input logic [IW-1:0] p,
    input int            k
  );
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // walk from farthest to nearest so the nearest hit wins
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_i[wrap_idx(ptr_i, k)]) begin
        any_o = 1'b1;
        idx_o = wrap_idx(ptr_i, k);
      end
    end
  end

endmodule

// File: rtl/apb4_master_arb.sv
// apb4_master_arb: shares one APB4 master port among NREQ
// requesters, one transfer at a time, with a wait-state timeout.
module apb4_master_arb
  import apb4_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int ADDRWIDTH = 12,
  parameter int TO_WD     = 8
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic [TO_WD-1:0]          to_limit,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0]           req_write,
  input  logic [NREQ*ADDRWIDTH-1:0] req_addr,
  input  logic [NREQ*APB_DW-1:0]    req_wdata,
  input  logic [NREQ*APB_SW-1:0]    req_strb,
  output logic [NREQ-1:0]           resp_valid,
  output logic [APB_DW-1:0]         resp_rdata,
  output logic                      resp_err,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDRWIDTH-1:0]      paddr,
  output logic [APB_DW-1:0]         pwdata,
  output logic [APB_SW-1:0]         pstrb,
  input  logic [APB_DW-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e                state_q, state_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]         g_q, g_d;
  logic                  write_q, write_d;
  logic [ADDRWIDTH-1:0]  addr_q, addr_d;
  logic [APB_DW-1:0]     wdata_q, wdata_d;
  logic [APB_SW-1:0]     strb_q, strb_d;
  logic [APB_DW-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [TO_WD-1:0]      to_cnt_q, to_cnt_d;

  logic                  pick_any;
  logic [IW-1:0]         pick_idx;
  logic                  to_hit;

  apb4_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  // to_limit is live: a mid-transfer change applies at once
  assign to_hit = (to_limit != '0) &&
                  (to_cnt_q == to_limit - TO_WD'(1));

  // next-state, request capture and handshake strobes
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    g_d        = g_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    to_cnt_d   = to_cnt_q;
    req_ready  = '0;
    resp_valid = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          req_ready = NREQ'(1) << pick_idx;
          g_d       = pick_idx;
          rr_ptr_d  = pick_idx;
          write_d   = req_write[pick_idx];
          addr_d    = req_addr[pick_idx*ADDRWIDTH +: ADDRWIDTH];
          wdata_d   = req_wdata[pick_idx*APB_DW +: APB_DW];
          strb_d    = req_write[pick_idx] ?
                      req_strb[pick_idx*APB_SW +: APB_SW] : '0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        to_cnt_d = to_cnt_q + TO_WD'(1);
        if (pready) begin
          rdata_d = write_q ? '0 : prdata;
          err_d   = pslverr;
          state_d = RESP;
        end else if (to_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid = NREQ'(1) << g_q;
        to_cnt_d   = '0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and arbitration pointer
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q  <= IDLE;
      rr_ptr_q <= IW'(NREQ - 1);
      g_q      <= '0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      g_q      <= g_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // latched request payload and slave response
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign psel       = (state_q == SETUP) || (state_q == ACCESS);
  assign penable    = (state_q == ACCESS);
  assign pwrite     = write_q;
  assign paddr      = addr_q;
  assign pwdata     = wdata_q;
  assign pstrb      = strb_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
